// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32
// load/store width codes and the access legality helpers.
package lsu_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_RMW_READ  = 3'd2;
    localparam logic [2:0] S_RMW_WRITE = 3'd3;
    localparam logic [2:0] S_WRITE     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    // RV32 func3 width/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know B/H/W; loads additionally have the unsigned variants.
    function automatic logic func3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for the load/store unit: picks and extends the addressed
// byte/half of a loaded word, and merges sub-word store data into a word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Select the addressed byte and halfword of the memory word (little-endian)
    always_comb begin
        sel_byte = read_word[7:0];
        case (byte_offset)
            2'd0: sel_byte = read_word[7:0];
            2'd1: sel_byte = read_word[15:8];
            2'd2: sel_byte = read_word[23:16];
            2'd3: sel_byte = read_word[31:24];
            default: sel_byte = read_word[7:0];
        endcase
        sel_half = byte_offset[1] ? read_word[31:16] : read_word[15:0];
    end

    // Sign- or zero-extend the selected lane to 32 bits
    always_comb begin
        load_value = read_word;
        case (func3)
            F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_value = {24'h0, sel_byte};
            F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_value = {16'h0, sel_half};
            default: load_value = read_word;
        endcase
    end

    // Replace the addressed byte/half of the read word with the store data
    always_comb begin
        merged_word = read_word;
        case (func3)
            F3_B: begin
                case (byte_offset)
                    2'd0: merged_word[7:0]   = store_data[7:0];
                    2'd1: merged_word[15:8]  = store_data[7:0];
                    2'd2: merged_word[23:16] = store_data[7:0];
                    2'd3: merged_word[31:24] = store_data[7:0];
                    default: merged_word = read_word;
                endcase
            end
            F3_H: begin
                if (byte_offset[1])
                    merged_word[31:16] = store_data[15:0];
                else
                    merged_word[15:0]  = store_data[15:0];
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of a word-wide data memory. Sub-word stores
// are done as read-modify-write. The pipeline is held via stall until the
// access reaches DONE, which lasts one cycle.
//
// Memory handshake: dmem_read / dmem_write act as valid and stay high until
// the transfer completes; dmem_busywait low acts as ready. A transfer
// completes at a posedge where the request is high and dmem_busywait is low.
// dmem_read and dmem_write are never high together.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic        stall,
    output logic [31:0] loaddata,
    output logic        access_error,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [5:0]  dmem_address,
    output logic [31:0] dmem_writedata,
    input  logic [31:0] dmem_readdata,
    input  logic        dmem_busywait,
    output logic [2:0]  debug_state
);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] merge_q;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;
    logic        req;
    logic        req_error;
    logic        xfer_done;
    logic        unused_addr_hi;

    // Only a 64-word window is addressed; the upper address bits are ignored.
    assign unused_addr_hi = ^address[31:8];

    assign req       = mem_read | mem_write;
    assign req_error = (mem_read & mem_write)
                     | ~func3_legal(mem_write, func3)
                     | misaligned(func3, address[1:0]);

    assign dmem_read      = (state == S_READ) || (state == S_RMW_READ);
    assign dmem_write     = (state == S_WRITE) || (state == S_RMW_WRITE);
    assign dmem_address   = address[7:2];
    assign dmem_writedata = (state == S_RMW_WRITE) ? merge_q : writedata;
    assign xfer_done      = (dmem_read | dmem_write) & ~dmem_busywait;

    assign stall       = req & (state != S_DONE);
    assign debug_state = state;

    lsu_byte_lane u_lane (
        .func3       (func3),
        .byte_offset (address[1:0]),
        .read_word   (dmem_readdata),
        .store_data  (writedata),
        .load_value  (lane_load),
        .merged_word (lane_merged)
    );

    // Next-state decode: errors short-circuit to DONE, sub-word stores go RMW
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (req_error)
                        state_next = S_DONE;
                    else if (mem_read)
                        state_next = S_READ;
                    else if (func3 == F3_W)
                        state_next = S_WRITE;
                    else
                        state_next = S_RMW_READ;
                end
            end
            S_READ:      if (xfer_done) state_next = S_DONE;
            S_RMW_READ:  if (xfer_done) state_next = S_RMW_WRITE;
            S_RMW_WRITE: if (xfer_done) state_next = S_DONE;
            S_WRITE:     if (xfer_done) state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Result, error flag and RMW merge registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            loaddata     <= '0;
            access_error <= 1'b0;
            merge_q      <= '0;
        end else begin
            // High only for the DONE cycle that follows a rejected request.
            access_error <= (state == S_IDLE) && req && req_error;
            // A rejected request with mem_read set counts as an errored load.
            if ((state == S_READ) && xfer_done)
                loaddata <= lane_load;
            else if ((state == S_IDLE) && mem_read && req_error)
                loaddata <= '0;
            if ((state == S_RMW_READ) && xfer_done)
                merge_q <= lane_merged;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory that
// inserts a programmable number of busywait cycles per transfer.
module tb_load_store_unit;
    import lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        stall;
    logic [31:0] loaddata;
    logic        access_error;
    logic        dmem_read;
    logic        dmem_write;
    logic [5:0]  dmem_address;
    logic [31:0] dmem_writedata;
    logic [31:0] dmem_readdata;
    logic        dmem_busywait;
    logic [2:0]  debug_state;

    load_store_unit dut (
        .clock          (clock),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .func3          (func3),
        .address        (address),
        .writedata      (writedata),
        .stall          (stall),
        .loaddata       (loaddata),
        .access_error   (access_error),
        .dmem_read      (dmem_read),
        .dmem_write     (dmem_write),
        .dmem_address   (dmem_address),
        .dmem_writedata (dmem_writedata),
        .dmem_readdata  (dmem_readdata),
        .dmem_busywait  (dmem_busywait),
        .debug_state    (debug_state)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:63];
    bit          mem_init  = 1'b0;
    int          rd_wait   = 0;
    int          wr_wait   = 0;
    int          busy_cnt  = 0;
    int          rd_xfers  = 0;
    int          wr_xfers  = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          both_cycles = 0;

    assign dmem_readdata = mem[dmem_address];
    assign dmem_busywait = (dmem_read && (busy_cnt < rd_wait)) ||
                           (dmem_write && (busy_cnt < wr_wait));

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_cnt <= 0;
            if (!mem_init) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
                mem[2] <= 32'h11223344;
                mem[3] <= 32'hDEADBEEF;
                mem[5] <= 32'h8899AABB;
                mem[7] <= 32'hCAFEF00D;
                mem[9] <= 32'h12345678;
                mem_init <= 1'b1;
            end
        end else if (dmem_read || dmem_write) begin
            if (dmem_busywait) begin
                busy_cnt <= busy_cnt + 1;
            end else begin
                busy_cnt <= 0;
                if (dmem_write) begin
                    mem[dmem_address] <= dmem_writedata;
                    wr_xfers <= wr_xfers + 1;
                end else begin
                    rd_xfers <= rd_xfers + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (dmem_read) rd_cycles++;
        if (dmem_write) wr_cycles++;
        if (dmem_read && dmem_write) both_cycles++;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] last_load = '0;
    int tests    = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int rwait, input int wwait,
                             input int exp_stall, input logic exp_err,
                             input logic [31:0] exp_load, input int exp_rx, input int exp_wx);
        int cnt;
        int rx0;
        int wx0;
        int cyc0;
        logic [31:0] exp_ld;
        rx0  = rd_xfers;
        wx0  = wr_xfers;
        cyc0 = rd_cycles + wr_cycles;
        rd_wait   = rwait;
        wr_wait   = wwait;
        mem_read  = rd;
        mem_write = wr;
        func3     = f3;
        address   = addr;
        writedata = wdata;
        if (rd && !wr) exp_q.push_back(exp_load);
        #1;
        cnt = 0;
        while (stall === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check({tag, " stall_cycles"}, cnt, exp_stall);
        check({tag, " done_state"}, debug_state, S_DONE);
        check({tag, " access_error"}, access_error, exp_err);
        if (rd && !wr) begin
            exp_ld = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
            check({tag, " loaddata"}, loaddata, exp_ld);
            last_load = exp_ld;
        end else if (!rd) begin
            check({tag, " loaddata_held"}, loaddata, last_load);
        end
        check({tag, " read_xfers"}, rd_xfers - rx0, exp_rx);
        check({tag, " write_xfers"}, wr_xfers - wx0, exp_wx);
        if (exp_err) check({tag, " no_mem_request"}, rd_cycles + wr_cycles - cyc0, 0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        check({tag, " error_cleared"}, access_error, 1'b0);
        check({tag, " back_idle"}, debug_state, S_IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        int wx0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        func3     = 3'b000;
        address   = '0;
        writedata = '0;
        reset     = 1'b0;
        repeat (3) tick();
        check("reset loaddata", loaddata, 32'h0);
        check("reset access_error", access_error, 1'b0);
        check("reset dmem_read", dmem_read, 1'b0);
        check("reset dmem_write", dmem_write, 1'b0);
        check("reset state", debug_state, S_IDLE);
        check("reset stall", stall, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        do_access("LB 0x16",  1, 0, F3_B,  32'h16, 0, 0, 0, 2, 0, 32'hFFFFFF99, 1, 0);
        do_access("LBU 0x16", 1, 0, F3_BU, 32'h16, 0, 0, 0, 2, 0, 32'h00000099, 1, 0);
        do_access("LH 0x14",  1, 0, F3_H,  32'h14, 0, 0, 0, 2, 0, 32'hFFFFAABB, 1, 0);
        do_access("LHU 0x16", 1, 0, F3_HU, 32'h16, 0, 0, 0, 2, 0, 32'h00008899, 1, 0);

        do_access("SH 0x0A", 0, 1, F3_H, 32'h0A, 32'h1234BEEF, 0, 0, 3, 0, 0, 1, 1);
        check("SH word2", mem[2], 32'hBEEF3344);
        do_access("SB 0x25", 0, 1, F3_B, 32'h25, 32'hFFFFFF5A, 0, 0, 3, 0, 0, 1, 1);
        check("SB word9", mem[9], 32'h12345A78);
        do_access("SW 0x20", 0, 1, F3_W, 32'h20, 32'hA5A50F0F, 0, 0, 2, 0, 0, 0, 1);
        check("SW word8", mem[8], 32'hA5A50F0F);

        do_access("LW 0x0C busy4", 1, 0, F3_W, 32'h0C, 0, 4, 0, 6, 0, 32'hDEADBEEF, 1, 0);
        do_access("LW 0x0D misaligned", 1, 0, F3_W, 32'h0D, 0, 0, 0, 1, 1, 32'h0, 0, 0);
        do_access("LW high addr", 1, 0, F3_W, 32'hFFFFFF24, 0, 0, 0, 2, 0, 32'h12345A78, 1, 0);
        do_access("SB 0x0B waits", 0, 1, F3_B, 32'h0B, 32'h00000000, 1, 2, 6, 0, 0, 1, 1);
        check("SB waits word2", mem[2], 32'h00EF3344);

        do_access("both high", 1, 1, F3_W, 32'h00, 0, 0, 0, 1, 1, 0, 0, 0);
        do_access("LD func3 011", 1, 0, 3'b011, 32'h00, 0, 0, 0, 1, 1, 32'h0, 0, 0);
        do_access("SH 0x0B misaligned", 0, 1, F3_H, 32'h0B, 32'hFFFF, 0, 0, 1, 1, 0, 0, 0);
        check("SH misaligned word2", mem[2], 32'h00EF3344);
        do_access("ST func3 100", 0, 1, F3_BU, 32'h00, 32'h55, 0, 0, 1, 1, 0, 0, 0);
        do_access("LW 0x1C", 1, 0, F3_W, 32'h1C, 0, 0, 0, 2, 0, 32'hCAFEF00D, 1, 0);

        // Reset in the middle of the write phase of a read-modify-write
        wx0       = wr_xfers;
        rd_wait   = 0;
        wr_wait   = 20;
        mem_write = 1'b1;
        func3     = F3_B;
        address   = 32'h1C;
        writedata = 32'h77;
        #1;
        cnt = 0;
        while (debug_state !== S_RMW_WRITE && cnt < 10) begin
            cnt++;
            tick();
        end
        check("rst reached RMW_WRITE", debug_state, S_RMW_WRITE);
        tick();
        tick();
        check("rst dmem_write busy", dmem_write, 1'b1);
        check("rst busywait", dmem_busywait, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst async dmem_write", dmem_write, 1'b0);
        check("rst async dmem_read", dmem_read, 1'b0);
        check("rst async state", debug_state, S_IDLE);
        check("rst async loaddata", loaddata, 32'h0);
        check("rst async access_error", access_error, 1'b0);
        mem_write = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        tick();
        check("rst word7 unchanged", mem[7], 32'hCAFEF00D);
        check("rst no write xfer", wr_xfers - wx0, 0);
        check("rst idle after", debug_state, S_IDLE);

        check("never read and write together", both_cycles, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
